mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 es_to_ms_valid  in  1  EX stage holds a valid instruction.
REQ-004 es_to_ms_bus  in  MS_BUS_IN_WD  {ex_flags[5:0], load_op[2:0], mem_req, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}.
REQ-005 ms_allowin  out  1  MEM can accept an instruction this cycle.
REQ-006 ws_allowin  in  1  WB can accept an instruction.
REQ-007 ws_block  in  1  WB flush (exception/ertn); kills MEM contents.
REQ-008 data_sram_data_ok  in  1  load/store response beat.
REQ-009 data_sram_rdata  in  32  load response data.
REQ-010 ms_to_ws_valid  out  1  MEM presents a completed instruction.
REQ-011 ms_to_ws_bus  out  MS_BUS_OUT_WD  {ex_flags[5:0], gr_we, dest[4:0], final_result[31:0], pc[31:0]}.
REQ-012 ms_to_ds_bus  out  39  {fwd_valid, fwd_ready, dest[4:0], fwd_data[31:0]} for ID hazard logic.

Function
REQ-013 ms_valid SHALL load es_to_ms_valid when ms_allowin=1; bus register SHALL capture only on es_to_ms_valid && ms_allowin.
REQ-014 ms_ready_go SHALL be 1 when (!mem_req || any ex_flag) or state=IDLE with data_ok=1 this cycle, or data already buffered.
REQ-015 ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go && !ws_block.
REQ-016 FSM states IDLE, WAIT_BUF, DISCARD.
REQ-017 IDLE->WAIT_BUF: data_ok arrives for valid mem_req instruction while ws_allowin=0; rdata SHALL be captured in a 32-bit buffer.
REQ-018 WAIT_BUF->IDLE: instruction leaves MEM; buffered data SHALL be used in place of data_sram_rdata.
REQ-019 Any state ->DISCARD: ws_block=1 while ms_valid, mem_req=1, no ex_flag, and response not yet received.
REQ-020 DISCARD->IDLE on data_ok; that beat SHALL be dropped; ms_allowin SHALL be 0 while in DISCARD.
REQ-021 ws_block=1 SHALL clear ms_valid next cycle regardless of state.
REQ-022 Load extraction by alu_result[1:0]: ld.b/ld.bu select byte, ld.h/ld.hu select halfword at bit 1, ld.w whole word; .b/.h sign-extend, .bu/.hu zero-extend to 32 bits.
REQ-023 final_result = extracted load data when load_op!=NONE, else alu_result.
REQ-024 Instruction with any ex_flag SHALL pass through without waiting for data_ok; ex_flags forwarded unmodified.
REQ-025 ms_to_ds_bus.dest SHALL be 0 when !ms_valid or !gr_we.

Reset
REQ-026 On reset: ms_valid=0, state=IDLE, buffer=0; ms_to_ws_valid=0, ms_allowin=1, ms_to_ds_bus=0.
REQ-027 Reset asserted in WAIT_BUF or DISCARD SHALL abandon the state; a later stray data_ok in IDLE with !ms_valid SHALL be ignored.

Configuration
REQ-028 Macro MS_BYPASS_EN defined: fwd_valid=ms_valid&&gr_we, fwd_ready=ms_ready_go, fwd_data=final_result.
REQ-029 Macro MS_BYPASS_EN undefined: fwd_ready=0, fwd_data=0; ID SHALL stall on any dest match.

Structure
REQ-030 Shared package SHALL hold MS_BUS_IN_WD, MS_BUS_OUT_WD, load_op encodings (NONE,B,BU,H,HU,W), FSM state encodings.
REQ-031 Sub-module mem_load_align SHALL implement REQ-022 combinationally.

Verification
REQ-032 ld.b addr=0x1003, rdata=0x80FF_1234, ws_allowin=1 -> final_result=0xFFFF_FF80 one cycle after data_ok.
REQ-033 ld.hu addr=0x1002, rdata=0x8001_0000 -> final_result=0x0000_8001.
REQ-034 data_ok with ws_allowin=0 for 3 cycles, rdata=0xDEAD_BEEF then changing -> state WAIT_BUF, forwarded value 0xDEAD_BEEF when ws_allowin rises.
REQ-035 ws_block while load awaits data_ok -> DISCARD, ms_allowin=0, next data_ok dropped, no ms_to_ws_valid, return IDLE.
REQ-036 ALU instruction dest=5, result=0x42, MS_BYPASS_EN defined -> ms_to_ds_bus={1,1,5,0x42}; undefined -> fwd_ready=0.
REQ-037 reset asserted in WAIT_BUF -> all outputs per REQ-026 next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared definitions for the MEM pipeline stage: bus widths,
//                bus layouts, load-op encodings and MEM FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int MS_BUS_IN_WD  = 80;
    localparam int MS_BUS_OUT_WD = 76;
    localparam int MS_BUS_DS_WD  = 39;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_BUF = 2'd1,
        S_DISCARD  = 2'd2
    } ms_state_e;

    // EX -> MEM bus layout, MSB first
    typedef struct packed {
        logic [5:0]  ex_flags;
        load_op_e    load_op;
        logic        mem_req;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    // MEM -> WB bus layout, MSB first
    typedef struct packed {
        logic [5:0]  ex_flags;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Pipeline handshake and data-SRAM response signals around the
//                MEM stage. 'slave' is the MEM stage view, 'master' is the
//                surrounding pipeline / memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;

    logic                                     es_to_ms_valid;
    logic [mem_stage_pkg::MS_BUS_IN_WD-1:0]   es_to_ms_bus;
    logic                                     ms_allowin;
    logic                                     ws_allowin;
    logic                                     ws_block;
    logic                                     data_sram_data_ok;
    logic [31:0]                              data_sram_rdata;
    logic                                     ms_to_ws_valid;
    logic [mem_stage_pkg::MS_BUS_OUT_WD-1:0]  ms_to_ws_bus;
    logic [mem_stage_pkg::MS_BUS_DS_WD-1:0]   ms_to_ds_bus;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, ws_block,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, ws_block,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
    );

endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_align
//  Description : Combinational load data extraction. Selects byte/halfword/
//                word from the 32-bit response using the low address bits and
//                sign- or zero-extends it to 32 bits.
//  Ports       : load_op_i  - load type
//                addr_lo_i  - address bits [1:0]
//                rdata_i    - raw 32-bit response word
//                data_o     - aligned, extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import mem_stage_pkg::*;
(
    input  load_op_e    load_op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // halfword loads only look at bit 1; bit 0 is ignored
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = rdata_i;
        case (load_op_i)
            LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data_o = {24'd0, byte_sel};
            LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Holds one instruction, waits for the
//                data-SRAM response of loads/stores, buffers an early response
//                when WB stalls, and drops the orphan response of an
//                instruction flushed by WB.
//  Ports       : clk    - pipeline clock
//                reset  - synchronous active-high reset
//                pipe   - mem_stage_if.slave (EX/WB handshakes, SRAM response,
//                         ID forwarding bus)
//  Config      : MS_BYPASS_EN - when defined, ms_to_ds_bus carries the result
//                for forwarding; otherwise fwd_ready/fwd_data are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  pipe
);

    logic        ms_valid_q, ms_valid_d;
    es_to_ms_t   ms_bus_q;
    ms_state_e   state_q, state_d;
    logic [31:0] buf_q, buf_d;

    logic        has_ex;
    logic        need_resp;
    logic        ms_ready_go;
    logic        ms_allowin;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        fwd_valid;
    logic        fwd_ready;
    logic [31:0] fwd_data;
    ms_to_ws_t   ws_bus;

    // Excepting instructions never touch memory, so they never wait.
    assign has_ex    = |ms_bus_q.ex_flags;
    assign need_resp = ms_bus_q.mem_req && !has_ex;

    assign ms_ready_go = !need_resp
                      || ((state_q == S_IDLE) && pipe.data_sram_data_ok)
                      || (state_q == S_WAIT_BUF);

    // While discarding, the SRAM still owes a beat; a new request must not
    // enter until it has been drained.
    assign ms_allowin = (state_q != S_DISCARD)
                     && (!ms_valid_q || (ms_ready_go && pipe.ws_allowin));

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (pipe.ws_block) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = pipe.es_to_ms_valid;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (ms_valid_q && need_resp) begin
                    if (pipe.ws_block) begin
                        // flushed before its beat arrived: drop that beat later
                        if (!pipe.data_sram_data_ok) begin
                            state_d = S_DISCARD;
                        end
                    end else if (pipe.data_sram_data_ok && !pipe.ws_allowin) begin
                        state_d = S_WAIT_BUF;
                        buf_d   = pipe.data_sram_rdata;
                    end
                end
            end
            S_WAIT_BUF: begin
                if (pipe.ws_block || pipe.ws_allowin) begin
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (pipe.data_sram_data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            state_q    <= S_IDLE;
            buf_q      <= 32'd0;
            ms_bus_q   <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            state_q    <= state_d;
            buf_q      <= buf_d;
            if (pipe.es_to_ms_valid && ms_allowin) begin
                ms_bus_q <= pipe.es_to_ms_bus;
            end
        end
    end

    assign load_src = (state_q == S_WAIT_BUF) ? buf_q : pipe.data_sram_rdata;

    mem_load_align u_align (
        .load_op_i (ms_bus_q.load_op),
        .addr_lo_i (ms_bus_q.alu_result[1:0]),
        .rdata_i   (load_src),
        .data_o    (load_data)
    );

    assign final_result = (ms_bus_q.load_op != LD_NONE) ? load_data
                                                        : ms_bus_q.alu_result;

    assign ws_bus.ex_flags     = ms_bus_q.ex_flags;
    assign ws_bus.gr_we        = ms_bus_q.gr_we;
    assign ws_bus.dest         = ms_bus_q.dest;
    assign ws_bus.final_result = final_result;
    assign ws_bus.pc           = ms_bus_q.pc;

    assign fwd_valid = ms_valid_q && ms_bus_q.gr_we;

`ifdef MS_BYPASS_EN
    assign fwd_ready = fwd_valid && ms_ready_go;
    assign fwd_data  = fwd_valid ? final_result : 32'd0;
`else
    // No bypass path: ID must stall on any destination match.
    assign fwd_ready = 1'b0;
    assign fwd_data  = 32'd0;
`endif

    assign pipe.ms_allowin     = ms_allowin;
    assign pipe.ms_to_ws_valid = ms_valid_q && ms_ready_go && !pipe.ws_block;
    assign pipe.ms_to_ws_bus   = ws_bus;
    assign pipe.ms_to_ds_bus   = {fwd_valid, fwd_ready,
                                  (fwd_valid ? ms_bus_q.dest : 5'd0), fwd_data};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Directed scenarios for
//                load extraction, response buffering, flush/discard, ex-flag
//                pass-through, forwarding bus and reset; then a randomized
//                run with an instruction-level reference model feeding a
//                scoreboard that a separate monitor drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if ifc ();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (ifc)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  ex;
        logic [2:0]  op;
        logic        mem_req;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
    } instr_t;

    logic [75:0] exp_q[$];
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end
    endtask

    // Reference load extraction written with plain shifts and arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            3'd5:    return w;
            default: return addr;
        endcase
    endfunction

    function automatic logic [75:0] exp_out(input instr_t i);
        logic [31:0] res;
        res = (i.op != 3'd0) ? ref_load(i.op, i.alu, i.rdata) : i.alu;
        return {i.ex, i.gr_we, i.dest, res, i.pc};
    endfunction

    function automatic logic [79:0] make_bus(input instr_t i);
        return {i.ex, i.op, i.mem_req, i.gr_we, i.dest, i.alu, i.pc};
    endfunction

    function automatic instr_t mk(input logic [5:0] ex, input logic [2:0] op, input logic mr,
                                  input logic we, input logic [4:0] d, input logic [31:0] alu,
                                  input logic [31:0] pc);
        instr_t i;
        i.ex = ex; i.op = op; i.mem_req = mr; i.gr_we = we;
        i.dest = d; i.alu = alu; i.pc = pc; i.rdata = 32'd0;
        return i;
    endfunction

    function automatic instr_t rand_instr(input logic [31:0] pc);
        instr_t i;
        i.pc    = pc;
        i.dest  = 5'($urandom);
        i.alu   = $urandom;
        i.rdata = $urandom;
        i.ex    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        if (i.ex != 6'd0) begin
            i.op      = 3'd0;
            i.mem_req = 1'($urandom_range(0, 1));
            i.gr_we   = 1'($urandom_range(0, 1));
        end else begin
            i.op      = 3'($urandom_range(0, 5));
            i.mem_req = (i.op != 3'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            i.gr_we   = (i.op != 3'd0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        return i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.es_to_ms_valid    = 1'b0;
        ifc.es_to_ms_bus      = '0;
        ifc.ws_allowin        = 1'b1;
        ifc.ws_block          = 1'b0;
        ifc.data_sram_data_ok = 1'b0;
        ifc.data_sram_rdata   = 32'd0;
    endtask

    // Present one instruction for a cycle; it is in MEM on return.
    task automatic load_mem(input instr_t i);
        ifc.es_to_ms_valid = 1'b1;
        ifc.es_to_ms_bus   = make_bus(i);
        @(negedge clk);
        chk("accept_allowin", ifc.ms_allowin, 1);
        step();
        ifc.es_to_ms_valid = 1'b0;
        ifc.es_to_ms_bus   = '0;
    endtask

    // Scoreboard monitor: every WB handshake pops one expected bus.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && ifc.ms_to_ws_valid && ifc.ws_allowin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got bus %h required no output", ifc.ms_to_ws_bus);
                end else begin
                    chk("sb_bus", ifc.ms_to_ws_bus, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        instr_t      i;
        logic [38:0] exp_ds;

        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ws_valid", ifc.ms_to_ws_valid, 0);
        chk("rst_allowin", ifc.ms_allowin, 1);
        chk("rst_ds_bus", ifc.ms_to_ds_bus, 0);
        step();
        reset = 1'b0;

        // ld.b at 0x1003
        load_mem(mk(6'd0, 3'd1, 1'b1, 1'b1, 5'd3, 32'h1003, 32'h100));
        @(negedge clk);
        chk("ldb_wait_valid", ifc.ms_to_ws_valid, 0);
        step();
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = 32'h80FF_1234;
        @(negedge clk);
        chk("ldb_valid", ifc.ms_to_ws_valid, 1);
        chk("ldb_result", ifc.ms_to_ws_bus[63:32], 32'hFFFF_FF80);
        step();
        ifc.data_sram_data_ok = 1'b0;

        // ld.hu at 0x1002
        load_mem(mk(6'd0, 3'd4, 1'b1, 1'b1, 5'd4, 32'h1002, 32'h104));
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = 32'h8001_0000;
        @(negedge clk);
        chk("ldhu_result", ifc.ms_to_ws_bus[63:32], 32'h0000_8001);
        step();
        ifc.data_sram_data_ok = 1'b0;

        // early response while WB stalls -> buffered
        ifc.ws_allowin = 1'b0;
        load_mem(mk(6'd0, 3'd5, 1'b1, 1'b1, 5'd6, 32'h2000, 32'h108));
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = 32'hDEAD_BEEF;
        step();
        ifc.data_sram_data_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifc.data_sram_rdata = $urandom;
            @(negedge clk);
            chk("buf_state", dut.state_q, S_WAIT_BUF);
            chk("buf_result", ifc.ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
            chk("buf_allowin", ifc.ms_allowin, 0);
            step();
        end
        ifc.ws_allowin      = 1'b1;
        ifc.data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("buf_out_valid", ifc.ms_to_ws_valid, 1);
        chk("buf_out_result", ifc.ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        chk("buf_idle", dut.state_q, S_IDLE);
        chk("buf_drained", ifc.ms_to_ws_valid, 0);
        step();

        // flush while waiting -> discard the late beat
        load_mem(mk(6'd0, 3'd5, 1'b1, 1'b1, 5'd7, 32'h3000, 32'h10C));
        ifc.ws_block = 1'b1;
        @(negedge clk);
        chk("blk_valid", ifc.ms_to_ws_valid, 0);
        step();
        ifc.ws_block = 1'b0;
        @(negedge clk);
        chk("dis_state", dut.state_q, S_DISCARD);
        chk("dis_allowin", ifc.ms_allowin, 0);
        step();
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = $urandom;
        @(negedge clk);
        chk("dis_beat_valid", ifc.ms_to_ws_valid, 0);
        chk("dis_beat_allowin", ifc.ms_allowin, 0);
        step();
        ifc.data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("dis_idle", dut.state_q, S_IDLE);
        chk("dis_allowin_back", ifc.ms_allowin, 1);
        chk("dis_no_valid", ifc.ms_to_ws_valid, 0);
        step();

        // excepting memory instruction passes without a response
        i = mk(6'h21, 3'd0, 1'b1, 1'b0, 5'd9, 32'h55, 32'h110);
        load_mem(i);
        @(negedge clk);
        chk("ex_valid", ifc.ms_to_ws_valid, 1);
        chk("ex_bus", ifc.ms_to_ws_bus, exp_out(i));
        step();

        // forwarding bus for an ALU result held in MEM
        ifc.ws_allowin = 1'b0;
        load_mem(mk(6'd0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h42, 32'h114));
`ifdef MS_BYPASS_EN
        exp_ds = {1'b1, 1'b1, 5'd5, 32'h42};
`else
        exp_ds = {1'b1, 1'b0, 5'd5, 32'h0};
`endif
        @(negedge clk);
        chk("fwd_bus", ifc.ms_to_ds_bus, exp_ds);
        ifc.ws_allowin = 1'b1;
        step();
        ifc.ws_allowin = 1'b0;
        load_mem(mk(6'd0, 3'd0, 1'b0, 1'b0, 5'd9, 32'h77, 32'h118));
        @(negedge clk);
        chk("fwd_nowe_dest", ifc.ms_to_ds_bus[36:32], 0);
        ifc.ws_allowin = 1'b1;
        step();

        // reset while buffered, then a stray beat
        ifc.ws_allowin = 1'b0;
        load_mem(mk(6'd0, 3'd5, 1'b1, 1'b1, 5'd8, 32'h4000, 32'h11C));
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = 32'hCAFE_F00D;
        step();
        ifc.data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("rst2_pre_state", dut.state_q, S_WAIT_BUF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_ws_valid", ifc.ms_to_ws_valid, 0);
        chk("rst2_allowin", ifc.ms_allowin, 1);
        chk("rst2_ds_bus", ifc.ms_to_ds_bus, 0);
        chk("rst2_state", dut.state_q, S_IDLE);
        step();
        ifc.data_sram_data_ok = 1'b1;
        ifc.data_sram_rdata   = $urandom;
        @(negedge clk);
        chk("stray_valid", ifc.ms_to_ws_valid, 0);
        step();
        ifc.data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk("stray_state", dut.state_q, S_IDLE);
        chk("stray_allowin", ifc.ms_allowin, 1);
        step();

        // randomized run against the instruction-level model
        begin
            localparam int N = 300;
            instr_t      cur, occ;
            bit          have_cur = 1'b0, occ_v = 1'b0, resp_done = 1'b0;
            bit          leave = 1'b0, enter = 1'b0, got = 1'b0, need;
            int          issued = 0, cycles = 0;
            logic [31:0] pc = 32'h8000;

            idle_inputs();
            mon_en = 1'b1;
            while ((issued < N || occ_v) && cycles < 20000) begin
                step();
                cycles++;
                if (got)   resp_done = 1'b1;
                if (leave) occ_v = 1'b0;
                if (enter) begin
                    occ       = cur;
                    occ_v     = 1'b1;
                    resp_done = 1'b0;
                    exp_q.push_back(exp_out(cur));
                    issued++;
                    have_cur  = 1'b0;
                end
                if (!have_cur && issued < N) begin
                    cur      = rand_instr(pc);
                    pc       = pc + 32'd4;
                    have_cur = 1'b1;
                end
                if (enter || !ifc.es_to_ms_valid)
                    ifc.es_to_ms_valid = have_cur && ($urandom_range(0, 3) != 0);
                ifc.es_to_ms_bus = make_bus(cur);
                ifc.ws_allowin   = ($urandom_range(0, 2) != 0);
                need = occ_v && occ.mem_req && (occ.ex == 6'd0) && !resp_done;
                if (need && $urandom_range(0, 2) == 0) begin
                    ifc.data_sram_data_ok = 1'b1;
                    ifc.data_sram_rdata   = occ.rdata;
                end else begin
                    ifc.data_sram_data_ok = 1'b0;
                    ifc.data_sram_rdata   = $urandom;
                end
                @(negedge clk);
                leave = ifc.ms_to_ws_valid && ifc.ws_allowin;
                enter = ifc.es_to_ms_valid && ifc.ms_allowin;
                got   = ifc.data_sram_data_ok;
            end
            mon_en = 1'b0;
            chk("rand_all_issued", issued, N);
            chk("rand_sb_empty", exp_q.size(), 0);
        end

        idle_inputs();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
